pattern_scan_ctrl: RTL and testbench

PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

---
 rtl/scan_pkg.sv | 39 +++
 rtl/pattern_matcher.sv | 40 ++++
 rtl/pattern_scan_ctrl.sv | 116 +++++++++++
 tb/tb_pattern_scan_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared constants, state encoding and configuration record for the pattern scanner.
package scan_pkg;

  localparam int unsigned PAT_W = 8;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned LEN_W = 4;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StArmed = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;
  localparam logic [1:0] StBad   = 2'd3;

  typedef struct packed {
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [CNT_W-1:0] target;
  } scan_cfg_t;

  // Length is kept in 1..PAT_W so the compare window is never empty or oversized.
  function automatic logic [LEN_W-1:0] norm_len(input logic [LEN_W-1:0] len);
    if (len == '0) begin
      return LEN_W'(1);
    end else if (len > LEN_W'(PAT_W)) begin
      return LEN_W'(PAT_W);
    end else begin
      return len;
    end
  endfunction

  function automatic logic [PAT_W-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [PAT_W-1:0] m;
    m = '0;
    for (int i = 0; i < int'(PAT_W); i++) begin
      m[i] = (i < int'(len));
    end
    return m;
  endfunction

endpackage

// File: rtl/pattern_matcher.sv
// Bit history shift register with a combinational compare of the window that
// includes the bit currently being shifted in.
module pattern_matcher
  import scan_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             shift_en_i,
  input  logic             bit_i,
  input  logic             clear_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             hit_o
);

  logic [PAT_W-1:0] hist_q, hist_d, hist_shift;

  // Bit 0 is always the newest bit.
  assign hist_shift = {hist_q[PAT_W-2:0], bit_i};

  always_comb begin
    hist_d = hist_q;
    if (clear_i) begin
      hist_d = '0;
    end else if (shift_en_i) begin
      hist_d = hist_shift;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign hit_o = shift_en_i & (((hist_shift ^ pattern_i) & len_mask(len_i)) == '0);

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Serial pattern scanner: counts (possibly overlapping) pattern matches in an
// accepted bit stream and stops after a configurable number of matches.
module pattern_scan_ctrl
  import scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  logic [1:0]       state_q, state_d;
  scan_cfg_t        cfg_q, cfg_d;
  logic [LEN_W-1:0] bits_q, bits_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             match_q, match_d;

  logic             accept;
  logic             scan_clear;
  logic             hit;
  logic             seen_enough;
  logic [CNT_W-1:0] count_inc;

  assign in_ready    = (state_q == StArmed);
  assign busy        = (state_q == StArmed);
  assign done        = (state_q == StDone);
  assign state       = state_q;
  assign match       = match_q;
  assign match_count = count_q;

  assign accept      = in_ready & in_valid & ~abort;
  assign seen_enough = (bits_q + LEN_W'(1)) >= cfg_q.len;
  assign count_inc   = (count_q == '1) ? count_q : count_q + CNT_W'(1);

  pattern_matcher u_matcher (
    .clk_i      (clk),
    .rst_i      (rst),
    .shift_en_i (accept),
    .bit_i      (in_bit),
    .clear_i    (scan_clear),
    .pattern_i  (cfg_q.pattern),
    .len_i      (cfg_q.len),
    .hit_o      (hit)
  );

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    bits_d     = bits_q;
    count_d    = count_q;
    match_d    = 1'b0;
    scan_clear = 1'b0;

    if (cfg_we && (state_q == StIdle || state_q == StDone)) begin
      cfg_d = '{pattern: cfg_pattern, len: norm_len(cfg_len), target: cfg_target};
    end

    if (abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_d    = StArmed;
            bits_d     = '0;
            count_d    = '0;
            scan_clear = 1'b1;
          end
        end
        StArmed: begin
          if (accept) begin
            bits_d = (bits_q == LEN_W'(PAT_W)) ? bits_q : bits_q + LEN_W'(1);
            if (hit && seen_enough) begin
              match_d = 1'b1;
              count_d = count_inc;
              // Leaving ARMED here drops in_ready while the final match is shown.
              if (cfg_q.target != '0 && count_inc == cfg_q.target) begin
                state_d = StDone;
              end
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cfg_q   <= '{pattern: '0, len: LEN_W'(1), target: '0};
      bits_q  <= '0;
      count_q <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      bits_q  <= bits_d;
      count_q <= count_d;
      match_q <= match_d;
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl with a queue-based reference model checked every cycle.
module tb_pattern_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst, cfg_we, start, abort, in_valid, in_bit;
  logic [7:0] cfg_pattern, cfg_target;
  logic [3:0] cfg_len;
  logic       in_ready, match, busy, done;
  logic [7:0] match_count;
  logic [1:0] state;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_state, m_count, m_pat, m_len, m_tgt;
  bit m_match;
  bit m_hist[$];

  pattern_scan_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_target  (cfg_target),
    .start       (start),
    .abort       (abort),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .in_ready    (in_ready),
    .match       (match),
    .match_count (match_count),
    .busy        (busy),
    .done        (done),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int  old_state;
    bit  acc;
    bit  hitm;
    old_state = m_state;
    if (rst) begin
      m_state = 0; m_count = 0; m_match = 0; m_hist.delete();
      m_pat = 0; m_len = 1; m_tgt = 0;
      return;
    end
    m_match = 0;
    acc = (old_state == 1) && in_valid && !abort;
    if (acc) begin
      m_hist.push_back(in_bit);
      if (m_hist.size() > 8) void'(m_hist.pop_front());
      if (m_hist.size() >= m_len) begin
        hitm = 1;
        for (int i = 0; i < m_len; i++) begin
          if (m_hist[m_hist.size() - 1 - i] != m_pat[i]) hitm = 0;
        end
        if (hitm) begin
          m_match = 1;
          if (m_count < 255) m_count++;
          if (m_tgt != 0 && m_count == m_tgt) m_state = 2;
        end
      end
    end
    if (cfg_we && (old_state == 0 || old_state == 2)) begin
      m_pat = cfg_pattern;
      m_len = (cfg_len == 0) ? 1 : ((cfg_len > 8) ? 8 : int'(cfg_len));
      m_tgt = cfg_target;
    end
    if (abort) begin
      m_state = 0;
    end else if (start && (old_state == 0 || old_state == 2)) begin
      m_state = 1; m_count = 0; m_hist.delete();
    end
  endtask

  task automatic check_all();
    cmp("state", 32'(state), 32'(m_state));
    cmp("in_ready", 32'(in_ready), 32'(m_state == 1));
    cmp("busy", 32'(busy), 32'(m_state == 1));
    cmp("done", 32'(done), 32'(m_state == 2));
    cmp("match", 32'(match), 32'(m_match));
    cmp("match_count", 32'(match_count), 32'(m_count));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic configure(input logic [7:0] p, input logic [3:0] l, input logic [7:0] t);
    cfg_we = 1; cfg_pattern = p; cfg_len = l; cfg_target = t;
    tick();
    cfg_we = 0;
  endtask

  task automatic do_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic do_abort();
    abort = 1; tick(); abort = 0;
  endtask

  task automatic send(input logic b, input logic exp_m);
    in_valid = 1; in_bit = b;
    tick();
    in_valid = 0;
    cmp("match_lit", 32'(match), 32'(exp_m));
    cmp("model_match_lit", 32'(m_match), 32'(exp_m));
  endtask

  // Bit 0 of bits/exp is sent/checked first.
  task automatic send_stream(input logic [15:0] bits, input logic [15:0] exp, input int n);
    for (int i = 0; i < n; i++) send(bits[i], exp[i]);
  endtask

  initial begin
    rst = 1; cfg_we = 0; start = 0; abort = 0; in_valid = 0; in_bit = 0;
    cfg_pattern = 0; cfg_len = 0; cfg_target = 0;
    tick();
    tick();
    rst = 0;
    cmp("reset_state", 32'(state), 32'd0);
    cmp("reset_count", 32'(match_count), 32'd0);

    // Overlapping 0110; a start while armed must be ignored
    configure(8'h06, 4'd4, 8'd0);
    do_start();
    send_stream(16'b0110, 16'b1000, 4);
    start = 1; send(1'b1, 1'b0); start = 0;
    send_stream(16'b01, 16'b10, 2);
    cmp("s1_count", 32'(match_count), 32'd2);

    // Target 3 on pattern 11: DONE after bit 4, bit 5 refused
    do_abort();
    configure(8'h03, 4'd2, 8'd3);
    do_start();
    send_stream(16'hF, 16'b1110, 4);
    cmp("s2_state_done", 32'(state), 32'd2);
    cmp("s2_ready_low", 32'(in_ready), 32'd0);
    send(1'b1, 1'b0);
    cmp("s2_count", 32'(match_count), 32'd3);

    // Abort beats a valid bit that would have matched
    configure(8'h03, 4'd2, 8'd0);
    do_start();
    send_stream(16'b11, 16'b10, 2);
    abort = 1; in_valid = 1; in_bit = 1;
    tick();
    abort = 0; in_valid = 0;
    cmp("s3_state", 32'(state), 32'd0);
    cmp("s3_count", 32'(match_count), 32'd1);
    cmp("s3_match", 32'(match), 32'd0);

    // Config write while armed is ignored
    configure(8'h0A, 4'd4, 8'd0);
    do_start();
    send_stream(16'b01, 16'b00, 2);
    cfg_we = 1; cfg_pattern = 8'h05; cfg_len = 4'd4;
    tick();
    cfg_we = 0;
    send_stream(16'b101, 16'b010, 3);
    cmp("s4_old_count", 32'(match_count), 32'd1);
    do_abort();
    configure(8'h05, 4'd4, 8'd0);
    do_start();
    send_stream(16'b10101, 16'b10000, 5);

    // Reset mid-scan with count 5, then restart
    do_abort();
    configure(8'h0F, 4'd4, 8'd0);
    do_start();
    send_stream(16'hFF, 16'b11111000, 8);
    cmp("s5_count5", 32'(match_count), 32'd5);
    rst = 1; start = 1; in_valid = 1; in_bit = 1;
    tick();
    rst = 0; start = 0; in_valid = 0;
    cmp("s5_rst_state", 32'(state), 32'd0);
    cmp("s5_rst_count", 32'(match_count), 32'd0);
    do_start();
    send_stream(16'b10, 16'b01, 2);
    do_abort();
    configure(8'h0F, 4'd4, 8'd0);
    do_start();
    send_stream(16'hF, 16'b1000, 4);

    // Length 0 acts as 1
    do_abort();
    configure(8'h01, 4'd0, 8'd0);
    do_start();
    send_stream(16'b1101, 16'b1101, 4);

    // Length above 8 acts as 8
    do_abort();
    configure(8'hFF, 4'd15, 8'd0);
    do_start();
    send_stream(16'h01FF, 16'h0180, 9);

    // Count saturates at 255
    do_abort();
    configure(8'h01, 4'd1, 8'd0);
    do_start();
    in_valid = 1; in_bit = 1;
    repeat (260) tick();
    in_valid = 0;
    cmp("sat_count", 32'(match_count), 32'd255);
    cmp("model_sat_count", 32'(m_count), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
